// File: rtl/comparator_pkg.sv
// Shared encodings and cascade resolution for the cascadable magnitude comparator.
// Result vectors are ordered {alb, aeb, agb} and are always one-hot.
package comparator_pkg;

   localparam int unsigned RES_W = 3;

   typedef logic [RES_W-1:0] cmp_res_t;

   localparam cmp_res_t CMP_LT = 3'b100;
   localparam cmp_res_t CMP_EQ = 3'b010;
   localparam cmp_res_t CMP_GT = 3'b001;

   // Local magnitude wins; on a tie the lower slice decides, illegal combinations fold to one-hot.
   function automatic cmp_res_t cmp_resolve(
      input logic mag_lt,
      input logic mag_gt,
      input logic cas_alb,
      input logic cas_aeb,
      input logic cas_agb
   );
      cmp_res_t res;
      res = CMP_EQ;
      if (mag_lt)       res = CMP_LT;
      else if (mag_gt)  res = CMP_GT;
      else if (cas_aeb) res = CMP_EQ;
      else if (cas_agb) res = CMP_GT;
      else if (cas_alb) res = CMP_LT;
      else              res = CMP_EQ;
      return res;
   endfunction

endpackage

// File: rtl/comparator_core.sv
// Combinational magnitude compare of one slice plus cascade resolution.
// Signed compares bias the sign bit so a single unsigned compare serves both modes.
module comparator_core
   import comparator_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SIGNED = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cas_alb,
   input  logic             cas_aeb,
   input  logic             cas_agb,
   output logic [RES_W-1:0] result_c
);

   localparam logic [WIDTH-1:0] SIGN_MASK =
      (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

   logic [WIDTH-1:0] a_key;
   logic [WIDTH-1:0] b_key;
   logic             mag_lt;
   logic             mag_gt;

   always_comb begin
      a_key  = a ^ SIGN_MASK;
      b_key  = b ^ SIGN_MASK;
      mag_lt = (a_key < b_key);
      mag_gt = (a_key > b_key);
   end

   assign result_c = cmp_resolve(mag_lt, mag_gt, cas_alb, cas_aeb, cas_agb);

endmodule

// File: rtl/comparator.sv
// Registered cascadable magnitude comparator (7485-style), one-cycle latency.
// Flags hold their last value while in_valid is low; out_valid tracks in_valid.
module comparator
   import comparator_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cas_alb,
   input  logic             cas_aeb,
   input  logic             cas_agb,
   output logic             alb,
   output logic             aeb,
   output logic             agb,
   output logic             out_valid
);

   logic [RES_W-1:0] result_c;
   logic [RES_W-1:0] res_q;
   logic             valid_q;

   comparator_core #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_core (
      .a        (a),
      .b        (b),
      .cas_alb  (cas_alb),
      .cas_aeb  (cas_aeb),
      .cas_agb  (cas_agb),
      .result_c (result_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) res_q <= result_c;
      end
   end

   assign {alb, aeb, agb} = res_q;
   assign out_valid       = valid_q;

endmodule

// File: tb/tb_comparator.sv
// Directed bench: unsigned and signed 4-bit slices share stimulus from a vector table,
// plus an 8-bit two-slice chain, async reset and idle-hold sequences.
module tb_comparator;
   import comparator_pkg::*;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] cas;      // {alb, aeb, agb}
      cmp_res_t   exp_uns;
      cmp_res_t   exp_sgn;
   } vec_t;

   localparam int NVEC = 13;

   logic clk = 1'b0;
   logic rst;
   logic       v_valid;
   logic [3:0] v_a, v_b;
   logic [2:0] v_cas;
   logic u_alb, u_aeb, u_agb, u_ov;
   logic s_alb, s_aeb, s_agb, s_ov;

   logic       c_valid;
   logic [3:0] c_lo_a, c_lo_b, c_hi_a, c_hi_b;
   logic lo_alb, lo_aeb, lo_agb, lo_ov;
   logic hi_alb, hi_aeb, hi_agb, hi_ov;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   comparator #(.WIDTH(4), .SIGNED(0)) u_uns (
      .clk(clk), .rst(rst), .in_valid(v_valid), .a(v_a), .b(v_b),
      .cas_alb(v_cas[2]), .cas_aeb(v_cas[1]), .cas_agb(v_cas[0]),
      .alb(u_alb), .aeb(u_aeb), .agb(u_agb), .out_valid(u_ov));

   comparator #(.WIDTH(4), .SIGNED(1)) u_sgn (
      .clk(clk), .rst(rst), .in_valid(v_valid), .a(v_a), .b(v_b),
      .cas_alb(v_cas[2]), .cas_aeb(v_cas[1]), .cas_agb(v_cas[0]),
      .alb(s_alb), .aeb(s_aeb), .agb(s_agb), .out_valid(s_ov));

   comparator #(.WIDTH(4), .SIGNED(0)) u_lo (
      .clk(clk), .rst(rst), .in_valid(c_valid), .a(c_lo_a), .b(c_lo_b),
      .cas_alb(1'b0), .cas_aeb(1'b1), .cas_agb(1'b0),
      .alb(lo_alb), .aeb(lo_aeb), .agb(lo_agb), .out_valid(lo_ov));

   // High slice sees the low slice's registered flags, so it samples one edge later.
   comparator #(.WIDTH(4), .SIGNED(0)) u_hi (
      .clk(clk), .rst(rst), .in_valid(lo_ov), .a(c_hi_a), .b(c_hi_b),
      .cas_alb(lo_alb), .cas_aeb(lo_aeb), .cas_agb(lo_agb),
      .alb(hi_alb), .aeb(hi_aeb), .agb(hi_agb), .out_valid(hi_ov));

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got {ov,alb,aeb,agb}=%b, expected %b", name, act, exp);
   endtask

   vec_t vecs [NVEC];

   initial begin
      vecs[0]  = '{4'd10, 4'd12, 3'b010, CMP_LT, CMP_LT};
      vecs[1]  = '{4'd15, 4'd0,  3'b010, CMP_GT, CMP_LT};
      vecs[2]  = '{4'd10, 4'd10, 3'b010, CMP_EQ, CMP_EQ};
      vecs[3]  = '{4'd15, 4'd1,  3'b010, CMP_GT, CMP_LT};
      vecs[4]  = '{4'd7,  4'd8,  3'b010, CMP_LT, CMP_GT};
      vecs[5]  = '{4'd6,  4'd6,  3'b001, CMP_GT, CMP_GT};
      vecs[6]  = '{4'd6,  4'd6,  3'b100, CMP_LT, CMP_LT};
      vecs[7]  = '{4'd6,  4'd6,  3'b000, CMP_EQ, CMP_EQ};
      vecs[8]  = '{4'd6,  4'd6,  3'b101, CMP_GT, CMP_GT};
      vecs[9]  = '{4'd6,  4'd6,  3'b111, CMP_EQ, CMP_EQ};
      vecs[10] = '{4'd0,  4'd0,  3'b010, CMP_EQ, CMP_EQ};
      vecs[11] = '{4'd3,  4'd5,  3'b001, CMP_LT, CMP_LT};
      vecs[12] = '{4'd8,  4'd0,  3'b010, CMP_GT, CMP_LT};

      rst = 1'b1; v_valid = 1'b0; v_a = '0; v_b = '0; v_cas = 3'b010;
      c_valid = 1'b0; c_lo_a = '0; c_lo_b = '0; c_hi_a = '0; c_hi_b = '0;
      @(posedge clk); #1;
      check("reset_uns", {u_ov, u_alb, u_aeb, u_agb}, 4'b0000);
      check("reset_sgn", {s_ov, s_alb, s_aeb, s_agb}, 4'b0000);
      check("reset_hi",  {hi_ov, hi_alb, hi_aeb, hi_agb}, 4'b0000);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back vectors: one result per edge, in order
      for (int i = 0; i < NVEC; i++) begin
         v_a = vecs[i].a; v_b = vecs[i].b; v_cas = vecs[i].cas; v_valid = 1'b1;
         @(posedge clk); #1;
         check($sformatf("vec%0d_uns", i), {u_ov, u_alb, u_aeb, u_agb}, {1'b1, vecs[i].exp_uns});
         check($sformatf("vec%0d_sgn", i), {s_ov, s_alb, s_aeb, s_agb}, {1'b1, vecs[i].exp_sgn});
      end

      // Idle: out_valid drops, flags hold last result (8 vs 0)
      v_valid = 1'b0; v_a = 4'd1; v_b = 4'd9; v_cas = 3'b000;
      @(posedge clk); #1;
      check("idle_uns", {u_ov, u_alb, u_aeb, u_agb}, {1'b0, CMP_GT});
      check("idle_sgn", {s_ov, s_alb, s_aeb, s_agb}, {1'b0, CMP_LT});

      // Async reset mid-cycle with in_valid high
      @(negedge clk);
      v_a = 4'd12; v_b = 4'd3; v_cas = 3'b010; v_valid = 1'b1;
      rst = 1'b1; #1;
      check("async_rst_uns", {u_ov, u_alb, u_aeb, u_agb}, 4'b0000);
      check("async_rst_sgn", {s_ov, s_alb, s_aeb, s_agb}, 4'b0000);
      @(posedge clk); #1;
      check("rst_held_uns", {u_ov, u_alb, u_aeb, u_agb}, 4'b0000);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_uns", {u_ov, u_alb, u_aeb, u_agb}, {1'b1, CMP_GT});
      check("post_rst_sgn", {s_ov, s_alb, s_aeb, s_agb}, {1'b1, CMP_LT});
      v_valid = 1'b0;

      // 8-bit chain: operands held two edges so the high slice sees the low result
      c_hi_a = 4'h5; c_lo_a = 4'hA; c_hi_b = 4'h5; c_lo_b = 4'hC; c_valid = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("chain_5A_5C", {hi_ov, hi_alb, hi_aeb, hi_agb}, {1'b1, CMP_LT});
      c_lo_b = 4'hA;
      @(posedge clk); @(posedge clk); #1;
      check("chain_5A_5A", {hi_ov, hi_alb, hi_aeb, hi_agb}, {1'b1, CMP_EQ});
      c_hi_a = 4'h6; c_lo_b = 4'hC;
      @(posedge clk); @(posedge clk); #1;
      check("chain_6A_5C", {hi_ov, hi_alb, hi_aeb, hi_agb}, {1'b1, CMP_GT});
      c_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("chain_idle", {hi_ov, hi_alb, hi_aeb, hi_agb}, {1'b0, CMP_GT});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
